// File: rtl/lbm_seq_pkg.sv
// ----------------------------------------------------------------------------
// lbm_seq_pkg : shared types and constants for the lattice chunk sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package lbm_seq_pkg;

  localparam int DEFAULT_ADDR_W = 12;
  localparam int NUM_DIRS       = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CSTART = 3'd2,
    ST_CWAIT  = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_NEXT   = 3'd5,
    ST_DONE   = 3'd6
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/bram_readback_stage.sv
// ----------------------------------------------------------------------------
// bram_readback_stage : read-address counter with 1-cycle-latency prefetch
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bram_readback_stage #(
  parameter int ADDR_W      = 12,
  parameter int CHUNK_WORDS = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              active,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] prefetch_addr,
  output logic              last_fire
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CHUNK_WORDS - 1);

  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              out_valid_q, out_valid_d;
  logic              fire;

  always_comb begin
    fire          = out_valid_q & out_ready;
    last_fire     = fire & (rd_addr_q == LAST_ADDR);
    // Present the next word's address on a fire so the data follows with no bubble.
    prefetch_addr = rd_addr_q + {{(ADDR_W-1){1'b0}}, fire};
    rd_addr_d     = rd_addr_q;
    out_valid_d   = 1'b0;
    if (start) begin
      rd_addr_d   = '0;
      out_valid_d = 1'b0;
    end else begin
      if (fire) rd_addr_d = rd_addr_q + ADDR_W'(1);
      out_valid_d = active & ~last_fire;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rd_addr_q   <= rd_addr_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: rtl/chunk_sequencer.sv
// ----------------------------------------------------------------------------
// chunk_sequencer : load -> compute -> writeback sequencing of one BRAM bank
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module chunk_sequencer
  import lbm_seq_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int CHUNK_WORDS = 4096,
  parameter int NUM_CHUNKS  = 16,
  parameter int IDX_W       = 4
) (
  input  logic              m00_axis_aclk,
  input  logic              m00_axis_areset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              chunk_transfer_ready,
  output logic              chunk_compute_ready,
  output logic [ADDR_W-1:0] DDR_addr,
  output logic              cache_wen,
  output logic              compute_start,
  input  logic              compute_done,
  output logic [IDX_W-1:0]  chunk_idx,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(CHUNK_WORDS - 1);
  localparam logic [IDX_W-1:0]  LAST_CHUNK = IDX_W'(NUM_CHUNKS - 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [IDX_W-1:0]  chunk_idx_q, chunk_idx_d;

  logic              rb_start, rb_active, rb_last_fire;
  logic [ADDR_W-1:0] rb_addr;

  bram_readback_stage #(
    .ADDR_W      (ADDR_W),
    .CHUNK_WORDS (CHUNK_WORDS)
  ) u_readback (
    .clk           (m00_axis_aclk),
    .rst           (m00_axis_areset),
    .start         (rb_start),
    .active        (rb_active),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .prefetch_addr (rb_addr),
    .last_fire     (rb_last_fire)
  );

  always_comb begin
    state_d              = state_q;
    wr_addr_d            = wr_addr_q;
    chunk_idx_d          = chunk_idx_q;
    in_ready             = 1'b0;
    chunk_transfer_ready = 1'b0;
    chunk_compute_ready  = 1'b0;
    DDR_addr             = '0;
    cache_wen            = 1'b0;
    compute_start        = 1'b0;
    frame_done           = 1'b0;
    rb_start             = 1'b0;
    rb_active            = 1'b0;
    busy                 = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          chunk_idx_d = '0;
          wr_addr_d   = '0;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        chunk_transfer_ready = 1'b1;
        in_ready             = 1'b1;
        DDR_addr             = wr_addr_q;
        cache_wen            = in_valid;
        if (in_valid) begin
          wr_addr_d = wr_addr_q + ADDR_W'(1);
          if (wr_addr_q == LAST_ADDR) state_d = ST_CSTART;
        end
      end
      ST_CSTART: begin
        chunk_compute_ready = 1'b1;
        compute_start       = 1'b1;
        state_d             = ST_CWAIT;
      end
      ST_CWAIT: begin
        chunk_compute_ready = 1'b1;
        if (compute_done) begin
          rb_start = 1'b1;
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        chunk_transfer_ready = 1'b1;
        rb_active            = 1'b1;
        DDR_addr             = rb_addr;
        if (rb_last_fire) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (chunk_idx_q == LAST_CHUNK) begin
          state_d = ST_DONE;
        end else begin
          chunk_idx_d = chunk_idx_q + IDX_W'(1);
          wr_addr_d   = '0;
          state_d     = ST_LOAD;
        end
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset) begin
      state_q     <= ST_IDLE;
      wr_addr_q   <= '0;
      chunk_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      chunk_idx_q <= chunk_idx_d;
    end
  end

  assign chunk_idx = chunk_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_chunk_sequencer.sv
// ----------------------------------------------------------------------------
// tb_chunk_sequencer : directed self-checking bench, 8-word chunks, 2 chunks
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_chunk_sequencer;

  localparam int ADDR_W      = 12;
  localparam int CHUNK_WORDS = 8;
  localparam int NUM_CHUNKS  = 2;
  localparam int IDX_W       = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic              compute_done = 1'b0;
  logic              in_ready, out_valid, chunk_transfer_ready, chunk_compute_ready;
  logic              cache_wen, compute_start, busy, frame_done;
  logic [ADDR_W-1:0] ddr_addr;
  logic [IDX_W-1:0]  chunk_idx;

  int n_checks = 0;
  int n_fail   = 0;

  chunk_sequencer #(
    .ADDR_W      (ADDR_W),
    .CHUNK_WORDS (CHUNK_WORDS),
    .NUM_CHUNKS  (NUM_CHUNKS),
    .IDX_W       (IDX_W)
  ) dut (
    .m00_axis_aclk        (clk),
    .m00_axis_areset      (rst),
    .start                (start),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .chunk_transfer_ready (chunk_transfer_ready),
    .chunk_compute_ready  (chunk_compute_ready),
    .DDR_addr             (ddr_addr),
    .cache_wen            (cache_wen),
    .compute_start        (compute_start),
    .compute_done         (compute_done),
    .chunk_idx            (chunk_idx),
    .busy                 (busy),
    .frame_done           (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_xfer"}, 32'(chunk_transfer_ready), 32'd0);
    check({tag, "_comp"}, 32'(chunk_compute_ready), 32'd0);
    check({tag, "_inrdy"}, 32'(in_ready), 32'd0);
    check({tag, "_oval"}, 32'(out_valid), 32'd0);
    check({tag, "_wen"}, 32'(cache_wen), 32'd0);
    check({tag, "_addr"}, 32'(ddr_addr), 32'd0);
    check({tag, "_cstart"}, 32'(compute_start), 32'd0);
    check({tag, "_fdone"}, 32'(frame_done), 32'd0);
  endtask

  task automatic load_full();
    for (int i = 0; i < CHUNK_WORDS; i++) begin
      in_valid = 1'b1;
      #1;
      check("load_wen", 32'(cache_wen), 32'd1);
      check("load_addr", 32'(ddr_addr), 32'(i));
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int rd;
    int stall;
    int cyc;

    repeat (3) @(posedge clk);
    #1;
    check_idle("rst");
    check("rst_idx", 32'(chunk_idx), 32'd0);
    rst = 1'b0;
    tick();
    check_idle("idle");

    // ---- chunk 0: continuous load ----
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check("ld_xfer", 32'(chunk_transfer_ready), 32'd1);
    check("ld_inrdy", 32'(in_ready), 32'd1);
    check("ld_addr0", 32'(ddr_addr), 32'd0);
    check("ld_busy", 32'(busy), 32'd1);
    check("ld_idx0", 32'(chunk_idx), 32'd0);
    load_full();

    compute_done = 1'b1;
    #1;
    check("cs_pulse", 32'(compute_start), 32'd1);
    check("cs_comp", 32'(chunk_compute_ready), 32'd1);
    check("cs_xfer", 32'(chunk_transfer_ready), 32'd0);
    tick();
    compute_done = 1'b0;
    #1;
    check("cw_pulse_gone", 32'(compute_start), 32'd0);
    check("cw_done_ignored", 32'(chunk_compute_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("cw_wait", 32'(chunk_compute_ready), 32'd1);
    end
    compute_done = 1'b1;
    tick();
    compute_done = 1'b0;
    out_ready = 1'b1;
    #1;
    check("dr_entry_xfer", 32'(chunk_transfer_ready), 32'd1);
    check("dr_entry_comp", 32'(chunk_compute_ready), 32'd0);
    check("dr_entry_oval", 32'(out_valid), 32'd0);
    check("dr_entry_addr", 32'(ddr_addr), 32'd0);
    tick();
    for (int i = 0; i < CHUNK_WORDS; i++) begin
      #1;
      check("dr_oval", 32'(out_valid), 32'd1);
      check("dr_prefetch", 32'(ddr_addr), 32'(i + 1));
      check("dr_wen", 32'(cache_wen), 32'd0);
      tick();
    end
    out_ready = 1'b0;
    check("next_oval", 32'(out_valid), 32'd0);
    check("next_xfer", 32'(chunk_transfer_ready), 32'd0);
    check("next_busy", 32'(busy), 32'd1);
    tick();

    // ---- chunk 1: toggling in_valid ----
    check("c1_idx", 32'(chunk_idx), 32'd1);
    check("c1_xfer", 32'(chunk_transfer_ready), 32'd1);
    for (int k = 0; k < 15; k++) begin
      in_valid = (k % 2 == 0);
      #1;
      check("tog_wen", 32'(cache_wen), 32'(k % 2 == 0));
      check("tog_addr", 32'(ddr_addr), 32'((k + 1) / 2));
      tick();
    end
    in_valid = 1'b0;
    check("c1_cstart", 32'(compute_start), 32'd1);
    tick();
    compute_done = 1'b1;
    tick();
    compute_done = 1'b0;
    out_ready = 1'b1;
    #1;
    check("c1_dr_addr0", 32'(ddr_addr), 32'd0);
    tick();

    // Drain with a 3-cycle backpressure stall at word 4.
    rd = 0;
    stall = 0;
    cyc = 0;
    while (rd < CHUNK_WORDS && cyc < 30) begin
      out_ready = !(rd == 4 && stall < 3);
      #1;
      check("st_oval", 32'(out_valid), 32'd1);
      check("st_addr", 32'(ddr_addr), 32'(rd + (out_ready ? 1 : 0)));
      tick();
      if (out_ready) rd++;
      else stall++;
      cyc++;
    end
    check("st_words", 32'(rd), 32'(CHUNK_WORDS));
    out_ready = 1'b0;
    check("st_oval_clr", 32'(out_valid), 32'd0);
    tick();
    check("done_pulse", 32'(frame_done), 32'd1);
    check("done_busy", 32'(busy), 32'd1);
    tick();
    check("post_fdone", 32'(frame_done), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_idx_hold", 32'(chunk_idx), 32'd1);

    // ---- async reset while in CWAIT ----
    start = 1'b1;
    tick();
    start = 1'b0;
    load_full();
    tick();
    tick();
    check("ar_cwait", 32'(chunk_compute_ready), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_idle("ar");
    check("ar_idx", 32'(chunk_idx), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check_idle("ar_post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
